// File: rtl/mem_pkg_hdl.sv
// Shared types and constants for the mem interface responder.
// The LFSR helper is only used when MEM_RESPONDER_LFSR_WAIT_EN is defined.
package mem_pkg_hdl;

    typedef enum logic [1:0] {
        MEM_RESP_IDLE,
        MEM_RESP_WAIT,
        MEM_RESP_RESP
    } mem_resp_state_t;

    localparam logic [15:0] MEM_RESP_LFSR_SEED = 16'hACE1;
    localparam int          MEM_RESP_MAX_WAIT  = 15;
    localparam int          MEM_RESP_CNT_W     = $clog2(MEM_RESP_MAX_WAIT + 1);

    typedef logic [MEM_RESP_CNT_W-1:0] mem_resp_cnt_t;

    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    function automatic logic [15:0] mem_resp_lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/mem_resp_wait_gen.sv
// Wait-count source for mem_responder: the fixed WAIT_STATES value, or with
// MEM_RESPONDER_LFSR_WAIT_EN the low nibble of an LFSR stepped on each load.
module mem_resp_wait_gen
    import mem_pkg_hdl::*;
#(
    parameter int WAIT_STATES = 2
) (
`ifdef MEM_RESPONDER_LFSR_WAIT_EN
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
`endif
    output mem_resp_cnt_t wait_o
);

`ifdef MEM_RESPONDER_LFSR_WAIT_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // The count presented at a capture is the pre-advance value.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = mem_resp_lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= MEM_RESP_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign wait_o = lfsr_q[MEM_RESP_CNT_W-1:0];
`else
    assign wait_o = mem_resp_cnt_t'(WAIT_STATES);
`endif

endmodule

// File: rtl/mem_responder.sv
// Target-side endpoint of the mem interface with its own storage array.
// Define MEM_RESPONDER_LFSR_WAIT_EN to draw per-transaction wait counts from an LFSR.
module mem_responder
    import mem_pkg_hdl::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  rwn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdy,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

    mem_resp_state_t       state_q, state_d;
    mem_resp_cnt_t         cnt_q, cnt_d;
    mem_resp_cnt_t         wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rwn_q, rwn_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  capture;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    assign capture = (state_q == MEM_RESP_IDLE) && cs;

    mem_resp_wait_gen #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_gen (
`ifdef MEM_RESPONDER_LFSR_WAIT_EN
        .clk    (clk),
        .rst    (rst),
        .load_i (capture),
`endif
        .wait_o (wait_cnt)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rwn_d   = rwn_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            MEM_RESP_IDLE: begin
                if (capture) begin
                    addr_d  = addr;
                    rwn_d   = rwn;
                    wdata_d = wdata;
                    if (wait_cnt == '0) begin
                        state_d = MEM_RESP_RESP;
                    end else begin
                        cnt_d   = wait_cnt - mem_resp_cnt_t'(1);
                        state_d = MEM_RESP_WAIT;
                    end
                end
            end
            MEM_RESP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = MEM_RESP_RESP;
                end else begin
                    cnt_d = cnt_q - mem_resp_cnt_t'(1);
                end
            end
            MEM_RESP_RESP: begin
                state_d = MEM_RESP_IDLE;
            end
            default: begin
                state_d = MEM_RESP_IDLE;
            end
        endcase

        // Read data is loaded on the edge entering RESP so it is valid alongside rdy.
        if (state_d == MEM_RESP_RESP && rwn_d) begin
            rdata_d = mem_q[addr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= MEM_RESP_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rwn_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rwn_q   <= rwn_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the storage array has no reset; clearing it would block RAM inference.
    always_ff @(posedge clk) begin
        if (state_q == MEM_RESP_RESP && !rwn_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign rdy   = (state_q == MEM_RESP_RESP);
    assign busy  = (state_q != MEM_RESP_IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (WAIT_STATES 2 and 0),
// expected responses queued at issue time and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int WS_A    = 2;
    localparam int WS_B    = 0;
    localparam int TIMEOUT = 40;

    typedef struct {
        bit            rwn;
        logic [DW-1:0] data;
        int            lat;
        int            cap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs    [2];
    logic          rwn   [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          rdy   [2];
    logic          busy  [2];
    logic [DW-1:0] rdata [2];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    exp_t          sb0 [$];
    exp_t          sb1 [$];
    logic [DW-1:0] ref_mem [2][256];
    bit            written [2][256];
    logic [DW-1:0] last_rd [2];
    logic [15:0]   lfsr_m  [2];
    logic [AW-1:0] pool    [8] = '{8'h00, 8'hFF, 8'h10, 8'h01, 8'h7F, 8'h80, 8'h33, 8'hC3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_STATES(WS_A)
    ) u_dut_a (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs[0]),
        .rwn  (rwn[0]),
        .addr (addr[0]),
        .wdata(wdata[0]),
        .rdy  (rdy[0]),
        .rdata(rdata[0]),
        .busy (busy[0])
    );

    mem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_STATES(WS_B)
    ) u_dut_b (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs[1]),
        .rwn  (rwn[1]),
        .addr (addr[1]),
        .wdata(wdata[1]),
        .rdy  (rdy[1]),
        .rdata(rdata[1]),
        .busy (busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference LFSR from the polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int   taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= s[16 - taps[i]];
        return (s >> 1) | (16'(fb) << 15);
    endfunction

    // Capture-to-rdy latency in cycles for the next transaction on instance d.
    function automatic int next_lat(input int d);
`ifdef MEM_RESPONDER_LFSR_WAIT_EN
        int l = int'(lfsr_m[d][3:0]) + 1;
        lfsr_m[d] = lfsr_step(lfsr_m[d]);
        return l;
`else
        return ((d == 0) ? WS_A : WS_B) + 1;
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = '0;
            lfsr_m[d]  = 16'hACE1;
        end
    endtask

    // Issue one request, queue its expected response, then wait for rdy (cs left high).
    task automatic txn(input int d, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t e;
        bit   seen = 1'b0;
        @(negedge clk);
        cs[d]    = 1'b1;
        rwn[d]   = rd;
        addr[d]  = a;
        wdata[d] = wd;
        e.rwn = rd;
        e.cap = cyc + 1;
        e.lat = next_lat(d);
        if (rd) begin
            e.data     = ref_mem[d][a];
            last_rd[d] = e.data;
        end else begin
            ref_mem[d][a] = wd;
            written[d][a] = 1'b1;
            e.data        = last_rd[d];
        end
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            @(negedge clk);
            seen = (rdy[d] === 1'b1);
        end
        if (!seen) begin
            check($sformatf("dut%0d rdy timeout addr %0h", d, a), 32'(seen), 32'd1);
            cs[d] = 1'b0;
        end
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk);
            cs[d] = 1'b0;
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   qsize = (d == 0) ? sb0.size() : sb1.size();
        if (qsize == 0) begin
            check($sformatf("dut%0d unexpected rdy", d), 32'(rdy[d]), 32'd0);
            return;
        end
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check($sformatf("dut%0d latency", d), 32'(cyc - e.cap + 1), 32'(e.lat));
        check($sformatf("dut%0d rdata (%s)", d, e.rwn ? "read" : "write"), 32'(rdata[d]), 32'(e.data));
        check($sformatf("dut%0d busy with rdy", d), 32'(busy[d]), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (rdy[d] === 1'b1) mon(d);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d rdy %s", d, tag), 32'(rdy[d]), 32'd0);
            check($sformatf("dut%0d busy %s", d, tag), 32'(busy[d]), 32'd0);
            check($sformatf("dut%0d rdata %s", d, tag), 32'(rdata[d]), 32'h0000);
        end
    endtask

    initial begin
        bit            rd;
        logic [AW-1:0] a;
        int            gap;

        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cs[d]    = 1'b0;
            rwn[d]   = 1'b0;
            addr[d]  = '0;
            wdata[d] = '0;
        end
        model_reset();

        repeat (3) @(negedge clk);
        check_idle_outputs("in reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("after release");

        // Write then read back with the fixed two-wait instance.
        txn(0, 1'b0, 8'h10, 16'hBEEF);
        idle(0, 1);
        txn(0, 1'b1, 8'h10, '0);
        idle(0, 2);

        // Zero-wait instance, back-to-back write then read with cs held.
        txn(1, 1'b0, 8'h01, 16'h1234);
        txn(1, 1'b1, 8'h01, '0);
        idle(1, 1);

        // Address extremes, and rdata holding across an intervening write.
        txn(0, 1'b0, 8'hFF, 16'hA5A5); idle(0, 1);
        txn(0, 1'b0, 8'h00, 16'h5A5A); idle(0, 1);
        txn(0, 1'b1, 8'hFF, '0);       idle(0, 1);
        txn(0, 1'b0, 8'h33, 16'h7777); idle(0, 1);
        txn(0, 1'b1, 8'h00, '0);       idle(0, 2);

        // Random mixed traffic; reads of never-written words become writes.
        for (int i = 0; i < 36; i++) begin
            int d = (i % 3 == 2) ? 1 : 0;
            rd = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
            if (rd && !written[d][a]) rd = 1'b0;
            txn(d, rd, a, 16'($urandom));
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(d, gap);
            else if (i % 3 == 1 || i % 3 == 2) idle(d, 1);
        end

        // Fill the pool, then 32 reads whose latencies track the wait sequence.
        foreach (pool[k]) begin
            txn(0, 1'b0, pool[k], 16'($urandom));
            idle(0, 1);
        end
        for (int i = 0; i < 32; i++) begin
            txn(0, 1'b1, pool[$urandom_range(0, 7)], '0);
            gap = $urandom_range(0, 1);
            if (gap > 0) idle(0, gap);
        end
        idle(0, 2);

        // Reset during an outstanding write: it must be dropped.
        txn(0, 1'b0, 8'h20, 16'h0001);
        idle(0, 1);
        @(negedge clk);
        cs[0]    = 1'b1;
        rwn[0]   = 1'b0;
        addr[0]  = 8'h20;
        wdata[0] = 16'hDEAD;
        @(posedge clk);
        #1;
        check("dut0 busy after capture", 32'(busy[0]), 32'd1);
        rst = 1'b0;
        #1;
        check("dut0 rdy on async reset", 32'(rdy[0]), 32'd0);
        check("dut0 busy on async reset", 32'(busy[0]), 32'd0);
        check("dut0 rdata on async reset", 32'(rdata[0]), 32'h0000);
        cs[0] = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        txn(0, 1'b1, 8'h20, '0);
        idle(0, 3);

        check("dut0 scoreboard drained", 32'(sb0.size()), 32'd0);
        check("dut1 scoreboard drained", 32'(sb1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
